// File: rtl/task_tone_mc_pkg.sv
// rtl/task_tone_mc_pkg.sv - shared types and constants for the zero-crossing tone counter
// Contents: FSM state enum, answer-word field offsets, empty-packet marker, word packer.
package task_tone_mc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    localparam int CH_LSB  = 24;
    localparam int WIN_LSB = 16;
    localparam int CNT_LSB = 0;

    localparam logic [31:0] EMPTY_MARKER = 32'hFFFF_0000;

    function automatic logic [31:0] pack_word(input logic [7:0] ch,
                                              input logic [7:0] win,
                                              input logic [15:0] cnt);
        return (32'(ch) << CH_LSB) | (32'(win) << WIN_LSB) | (32'(cnt) << CNT_LSB);
    endfunction

endpackage

// File: rtl/task_tone_fifo.sv
// rtl/task_tone_fifo.sv - synchronous FIFO holding answer words
// Ports: clk, rst_n (async active-low), push/wdata, pop/rdata, full, empty,
//        free (empty slots), count (occupied slots). rdata reads 0 while empty.
module task_tone_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      free,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      used;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            if (do_push && !do_pop)      used <= used + (AW+1)'(1);
            else if (!do_push && do_pop) used <= used - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    assign full  = (used == (AW+1)'(DEPTH));
    assign empty = (used == '0);
    assign free  = (AW+1)'(DEPTH) - used;
    assign count = used;
    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/task_tone_mc.sv
// rtl/task_tone_mc.sv - per-channel sign-change counter over interleaved byte-serial samples
// Ports: i_clk, i_rst (async active-low); byte input i_tdata_valid/i_tdata/i_tdata_last with
//        o_tready; answer output o_tanswer_ready/o_tanswer_data/o_tanswer_data_last with
//        i_tmanager_ready; o_packet_size_in_bytes = 4 x words queued in the current packet.
// Build option: PARTIAL_FLUSH_EN makes the end of a packet emit partial-window counts.
module task_tone_mc
    import task_tone_mc_pkg::*;
#(
    parameter int SAMPLE_BYTES = 2,
    parameter int NUM_CH       = 4,
    parameter int WINDOW       = 64,
    parameter int OUT_DEPTH    = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_tdata_valid,
    input  logic [7:0]  i_tdata,
    input  logic        i_tdata_last,
    output logic        o_tready,
    input  logic        i_tmanager_ready,
    output logic        o_tanswer_ready,
    output logic [31:0] o_tanswer_data,
    output logic        o_tanswer_data_last,
    output logic [11:0] o_packet_size_in_bytes
);

    localparam int SW     = 8 * SAMPLE_BYTES;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int BYTE_W = (SAMPLE_BYTES > 1) ? $clog2(SAMPLE_BYTES) : 1;
    localparam int FAW    = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;

    state_t            state;
    logic              rst_done;
    logic [SW-1:0]     sample_q;
    logic [SW-1:0]     sample_next;
    logic [BYTE_W-1:0] byte_cnt;
    logic [CH_W-1:0]   ch_idx;
    logic [15:0]       win_cnt;
    logic [7:0]        win_idx;
    logic [NUM_CH-1:0] signs;
    logic [15:0]       cnts [NUM_CH];
    logic [15:0]       snap [NUM_CH];
    logic [7:0]        snap_win;
    logic              emit_active;
    logic [CH_W-1:0]   emit_idx;
    logic [11:0]       size;

    logic              accept, sample_done, new_neg, crossing, win_done;
    logic              emit_push, emit_last, partial_needed, marker_push;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0]       fifo_wdata;
    logic [FAW:0]      fifo_free, fifo_count;

    // Little-endian assembly: each new byte lands on top and earlier bytes slide down.
    assign sample_next = (sample_q >> 8) | (SW'(i_tdata) << (8 * (SAMPLE_BYTES - 1)));

    always_comb begin
        accept         = i_tdata_valid && o_tready;
        sample_done    = accept && (byte_cnt == BYTE_W'(SAMPLE_BYTES - 1));
        new_neg        = |(sample_next >> (SW - 1));
        // The first sample of a window only loads the sign.
        crossing       = sample_done && (win_cnt != 16'd0) && (signs[ch_idx] != new_neg);
        win_done       = sample_done && (ch_idx == CH_W'(NUM_CH - 1))
                         && (win_cnt == 16'(WINDOW - 1));
        emit_push      = emit_active && !fifo_full;
        emit_last      = emit_push && (emit_idx == CH_W'(NUM_CH - 1));
`ifdef PARTIAL_FLUSH_EN
        partial_needed = (win_cnt != 16'd0) || (ch_idx != '0);
`else
        partial_needed = 1'b0;
`endif
        marker_push    = (state == FLUSH) && !emit_active && !partial_needed
                         && (size == 12'd0) && !fifo_full;
        fifo_push      = emit_push || marker_push;
        fifo_wdata     = emit_push ? pack_word(8'(emit_idx), snap_win, snap[emit_idx])
                                   : EMPTY_MARKER;
        fifo_pop       = !fifo_empty && i_tmanager_ready;
    end

    task_tone_fifo #(.WIDTH(32), .DEPTH(OUT_DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (o_tanswer_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .free  (fifo_free),
        .count (fifo_count)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state       <= IDLE;
            rst_done    <= 1'b0;
            sample_q    <= '0;
            byte_cnt    <= '0;
            ch_idx      <= '0;
            win_cnt     <= '0;
            win_idx     <= '0;
            signs       <= '0;
            snap_win    <= '0;
            emit_active <= 1'b0;
            emit_idx    <= '0;
            size        <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                cnts[i] <= '0;
                snap[i] <= '0;
            end
        end else begin
            rst_done <= 1'b1;
            if (accept) begin
                sample_q <= sample_next;
                // A last byte drops any half-assembled sample.
                byte_cnt <= (sample_done || i_tdata_last) ? '0 : byte_cnt + BYTE_W'(1);
            end
            if (sample_done) begin
                signs[ch_idx] <= new_neg;
                if (crossing) cnts[ch_idx] <= cnts[ch_idx] + 16'd1;
                if (ch_idx == CH_W'(NUM_CH - 1)) begin
                    ch_idx  <= '0;
                    win_cnt <= win_done ? 16'd0 : win_cnt + 16'd1;
                end else begin
                    ch_idx <= ch_idx + CH_W'(1);
                end
            end
            if (emit_push) begin
                if (emit_last) emit_active <= 1'b0;
                else           emit_idx    <= emit_idx + CH_W'(1);
            end
            // Snapshot includes the crossing found by the window's final sample.
            if (win_done) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    snap[i] <= (CH_W'(i) == ch_idx && crossing) ? cnts[i] + 16'd1 : cnts[i];
                    cnts[i] <= '0;
                end
                snap_win    <= win_idx;
                win_idx     <= win_idx + 8'd1;
                emit_active <= 1'b1;
                emit_idx    <= '0;
            end
            if (fifo_push) size <= size + 12'd4;

            case (state)
                IDLE: if (accept) begin
                    size  <= '0;
                    state <= i_tdata_last ? FLUSH : COLLECT;
                end
                COLLECT: if (accept && i_tdata_last) state <= FLUSH;
                FLUSH: begin
                    // Enter DRAIN on the cycle of the final push so that word is still queued.
                    if (emit_active) begin
                        if (emit_last && !partial_needed) state <= DRAIN;
                    end else if (partial_needed) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            snap[i] <= cnts[i];
                            cnts[i] <= '0;
                        end
                        snap_win    <= win_idx;
                        emit_active <= 1'b1;
                        emit_idx    <= '0;
                        ch_idx      <= '0;
                        win_cnt     <= '0;
                    end else if (size != 12'd0 || !fifo_full) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    byte_cnt <= '0;
                    ch_idx   <= '0;
                    win_cnt  <= '0;
                    win_idx  <= '0;
                    signs    <= '0;
                    for (int i = 0; i < NUM_CH; i++) cnts[i] <= '0;
                    if (fifo_empty || (fifo_pop && fifo_count == (FAW+1)'(1))) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_tready = rst_done && (state == IDLE || state == COLLECT)
                      && (fifo_free >= (FAW+1)'(NUM_CH));
    assign o_tanswer_ready        = !fifo_empty;
    assign o_tanswer_data_last    = (state == DRAIN) && (fifo_count == (FAW+1)'(1));
    assign o_packet_size_in_bytes = size;

endmodule

// File: tb/tb_task_tone_mc.sv
// tb/tb_task_tone_mc.sv - scoreboard bench for task_tone_mc (NUM_CH=2, WINDOW=4, OUT_DEPTH=4)
module tb_task_tone_mc;

    localparam int NUM_CH = 2;
    localparam int WINDOW = 4;
    localparam int SB     = 2;
    localparam int DEPTH  = 4;

    logic        i_clk, i_rst;
    logic        i_tdata_valid, i_tdata_last, i_tmanager_ready;
    logic [7:0]  i_tdata;
    logic        o_tready, o_tanswer_ready, o_tanswer_data_last;
    logic [31:0] o_tanswer_data;
    logic [11:0] o_packet_size_in_bytes;

    task_tone_mc #(.SAMPLE_BYTES(SB), .NUM_CH(NUM_CH), .WINDOW(WINDOW), .OUT_DEPTH(DEPTH)) dut (
        .i_clk                  (i_clk),
        .i_rst                  (i_rst),
        .i_tdata_valid          (i_tdata_valid),
        .i_tdata                (i_tdata),
        .i_tdata_last           (i_tdata_last),
        .o_tready               (o_tready),
        .i_tmanager_ready       (i_tmanager_ready),
        .o_tanswer_ready        (o_tanswer_ready),
        .o_tanswer_data         (o_tanswer_data),
        .o_tanswer_data_last    (o_tanswer_data_last),
        .o_packet_size_in_bytes (o_packet_size_in_bytes)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        bit          chk_last;
        bit          last;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] ch0_pat [4] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF9C};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input bit chk, input bit l);
        exp_t e;
        e.data     = d;
        e.chk_last = chk;
        e.last     = l;
        sb_q.push_back(e);
    endtask

    // Monitor: every handshake pops one expected word.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst && o_tanswer_ready && i_tmanager_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word: got %h expected none", o_tanswer_data);
                end else begin
                    e = sb_q.pop_front();
                    if (o_tanswer_data !== e.data) begin
                        errors++;
                        $display("FAIL word_data: got %h expected %h", o_tanswer_data, e.data);
                    end
                    if (e.chk_last) begin
                        checks++;
                        if (o_tanswer_data_last !== e.last) begin
                            errors++;
                            $display("FAIL word_last for %h: got %0b expected %0b",
                                     e.data, o_tanswer_data_last, e.last);
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit last);
        int n;
        bit acc;
        n = 0;
        acc = 1'b0;
        i_tdata_valid = 1'b1;
        i_tdata       = b;
        i_tdata_last  = last;
        while (!acc && n < 500) begin
            @(negedge i_clk);
            acc = o_tready;
            @(posedge i_clk);
            #1;
            n++;
        end
        i_tdata_valid = 1'b0;
        i_tdata_last  = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no o_tready expected accept of %h", b);
        end
    endtask

    task automatic send_sample(input logic [15:0] s, input bit last);
        send_byte(s[7:0], 1'b0);
        send_byte(s[15:8], last);
    endtask

    task automatic send_pairs(input int n, input bit last_at_end);
        for (int k = 0; k < n; k++) begin
            send_sample(ch0_pat[k % 4], 1'b0);
            send_sample(16'h0010, last_at_end && (k == n - 1));
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        while (!done && n < 500) begin
            @(negedge i_clk);
            done = o_tready && !o_tanswer_ready;
            n++;
        end
        @(posedge i_clk);
        #1;
        check({name, "_idle"}, 32'(done), 32'd1);
        check({name, "_sb_empty"}, sb_q.size(), 0);
    endtask

    task automatic run_basic(input string name);
        expect_word(32'h0000_0003, 1'b1, 1'b0);
        expect_word(32'h0100_0000, 1'b1, 1'b1);
        send_pairs(4, 1'b1);
        wait_idle(name);
        check({name, "_size"}, 32'(o_packet_size_in_bytes), 32'd8);
    endtask

    initial begin
        i_rst = 1'b0;
        i_tdata_valid = 1'b0;
        i_tdata = 8'h00;
        i_tdata_last = 1'b0;
        i_tmanager_ready = 1'b1;
        repeat (3) @(negedge i_clk);
        check("rst_tready", 32'(o_tready), 32'd0);
        check("rst_ans_ready", 32'(o_tanswer_ready), 32'd0);
        check("rst_ans_data", o_tanswer_data, 32'd0);
        check("rst_ans_last", 32'(o_tanswer_data_last), 32'd0);
        check("rst_size", 32'(o_packet_size_in_bytes), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        check("tready_before_clock", 32'(o_tready), 32'd0);
        @(negedge i_clk);
        check("tready_after_clock", 32'(o_tready), 32'd1);
        @(posedge i_clk);
        #1;

        run_basic("full_window");

        expect_word(32'hFFFF_0000, 1'b1, 1'b1);
        send_byte(8'h12, 1'b1);
        wait_idle("empty_packet");
        check("empty_packet_size", 32'(o_packet_size_in_bytes), 32'd4);

`ifdef PARTIAL_FLUSH_EN
        expect_word(32'h0000_0003, 1'b1, 1'b0);
        expect_word(32'h0100_0000, 1'b1, 1'b0);
        expect_word(32'h0001_0001, 1'b1, 1'b0);
        expect_word(32'h0101_0000, 1'b1, 1'b1);
        send_pairs(6, 1'b1);
        wait_idle("partial");
        check("partial_size", 32'(o_packet_size_in_bytes), 32'd16);
`else
        expect_word(32'h0000_0003, 1'b0, 1'b0);
        expect_word(32'h0100_0000, 1'b0, 1'b0);
        send_pairs(6, 1'b1);
        wait_idle("partial");
        check("partial_size", 32'(o_packet_size_in_bytes), 32'd8);
`endif

        expect_word(32'h0000_0003, 1'b0, 1'b0);
        expect_word(32'h0100_0000, 1'b0, 1'b0);
        send_pairs(4, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        send_byte(8'h55, 1'b1);
        wait_idle("half_sample");
        check("half_sample_size", 32'(o_packet_size_in_bytes), 32'd8);

        for (int w = 0; w < 3; w++) begin
            expect_word(32'h0000_0003 | (32'(w) << 16), 1'b1, 1'b0);
            expect_word(32'h0100_0000 | (32'(w) << 16), 1'b1, w == 2);
        end
        i_tmanager_ready = 1'b0;
        fork
            send_pairs(12, 1'b1);
            begin
                int n;
                logic [31:0] held;
                n = 0;
                @(negedge i_clk);
                while (o_tready && n < 300) begin
                    @(negedge i_clk);
                    n++;
                end
                check("stall_tready_low_seen", 32'(o_tready), 32'd0);
                held = o_tanswer_data;
                check("stall_head_word", held, 32'h0000_0003);
                for (int c = 0; c < 20; c++) begin
                    @(negedge i_clk);
                    check("stall_tready", 32'(o_tready), 32'd0);
                    check("stall_ans_ready", 32'(o_tanswer_ready), 32'd1);
                    check("stall_data_hold", o_tanswer_data, held);
                end
                @(posedge i_clk);
                #1 i_tmanager_ready = 1'b1;
            end
        join
        wait_idle("backpressure");
        check("backpressure_size", 32'(o_packet_size_in_bytes), 32'd24);

        send_sample(16'h0064, 1'b0);
        send_byte(8'h10, 1'b0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        check("midrst_tready", 32'(o_tready), 32'd0);
        check("midrst_ans_ready", 32'(o_tanswer_ready), 32'd0);
        check("midrst_ans_data", o_tanswer_data, 32'd0);
        check("midrst_size", 32'(o_packet_size_in_bytes), 32'd0);
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(negedge i_clk);
        check("midrst_tready_before_clock", 32'(o_tready), 32'd0);
        @(negedge i_clk);
        check("midrst_tready_after_clock", 32'(o_tready), 32'd1);
        @(posedge i_clk);
        #1;
        run_basic("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/task_tone_mc.md
TASK_TONE_MC -- requirements
Module: task_tone_mc

Interface
REQ-001 SHALL have parameter SAMPLE_BYTES, default 2: bytes per signed sample, range 1..4.
REQ-002 SHALL have parameter NUM_CH, default 4: interleaved channel count, range 1..16.
REQ-003 SHALL have parameter WINDOW, default 64: samples per channel per window, range 2..65535.
REQ-004 SHALL have parameter OUT_DEPTH, default 8: result FIFO words, at least NUM_CH, power of 2.
REQ-005 SHALL have port i_clk, input, 1: the single clock; all logic rises on it.
REQ-006 SHALL have port i_rst, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_tdata_valid, input, 1: input byte valid.
REQ-008 SHALL have port i_tdata, input, 8: input byte.
REQ-009 SHALL have port i_tdata_last, input, 1: marks the final byte of a packet.
REQ-010 SHALL have port o_tready, output, 1: data request.
REQ-011 SHALL have port i_tmanager_ready, input, 1: sink accepts an answer word.
REQ-012 SHALL have port o_tanswer_ready, output, 1: answer word valid.
REQ-013 SHALL have port o_tanswer_data, output, 32: answer word.
REQ-014 SHALL have port o_tanswer_data_last, output, 1: final answer word of the packet.
REQ-015 SHALL have port o_packet_size_in_bytes, output, 12: 4 x answer words queued so far in the current packet.

Function
REQ-016 SHALL accept a byte only when i_tdata_valid and o_tready are both high.
REQ-017 SHALL assemble SAMPLE_BYTES accepted bytes little-endian into one signed sample; sample n goes to channel n mod NUM_CH.
REQ-018 SHALL keep a per-channel previous-sign bit, where zero counts as non-negative; it increments the channel count when the sign differs; a window's first sample only loads the sign.
REQ-019 SHALL push NUM_CH words into the FIFO, channels 0..NUM_CH-1, on the cycle after the sample completing channel NUM_CH-1's WINDOW-th sample is accepted; it then clears the counts and the window sample counter.
REQ-020 SHALL format each word as [31:24] channel, [23:16] window index mod 256, [15:0] crossing count.
REQ-021 SHALL have FSM states IDLE, COLLECT, FLUSH and DRAIN; IDLE goes to COLLECT on the first accepted byte; COLLECT goes to FLUSH on an accepted i_tdata_last; FLUSH goes to DRAIN after pushing its words; DRAIN goes to IDLE when the last word handshakes.
REQ-022 SHALL drive o_tready high only in IDLE or COLLECT, and only with FIFO free slots of at least NUM_CH.
REQ-023 SHALL drive o_tanswer_ready as FIFO non-empty, in any state; a word pops when o_tanswer_ready and i_tmanager_ready are both high.
REQ-024 SHALL assert o_tanswer_data_last only in DRAIN with exactly one word left.
REQ-025 SHALL discard an incomplete trailing sample when i_tdata_last arrives.
REQ-026 SHALL treat a last byte that also completes a window as a full window; FLUSH then adds no partial words.
REQ-027 SHALL make FLUSH push exactly one word 32'hFFFF_0000 if the packet produced no words.
REQ-028 SHALL hold o_tanswer_data and o_tanswer_data_last stable while o_tanswer_ready is high and i_tmanager_ready is low.

Reset
REQ-029 SHALL, while i_rst is low, force the FSM to IDLE, empty the FIFO, and clear counters, signs, the byte assembler and the size counter.
REQ-030 SHALL hold o_tready, o_tanswer_ready and o_tanswer_data_last at 0, and o_tanswer_data and o_packet_size_in_bytes at 0, during reset.
REQ-031 SHALL discard all in-flight data on a reset mid-packet; o_tready rises on the first clock after release.

Configuration
REQ-032 SHALL, with PARTIAL_FLUSH_EN defined, make FLUSH push NUM_CH words of partial counts when the window holds any accepted sample.
REQ-033 SHALL, without PARTIAL_FLUSH_EN, make FLUSH drop partial counts; only REQ-027 can add a word.

Structure
REQ-034 SHALL place the FSM state enum, the word field offsets and the 32'hFFFF_0000 empty marker in package task_tone_mc_pkg.
REQ-035 SHALL implement the FIFO as sub-module task_tone_fifo (parameters WIDTH and DEPTH; push, pop, full, empty, free count).

Verification
REQ-036 SHALL cover, with NUM_CH=2 and WINDOW=4: ch0 = 0x0064, 0xFF9C, 0x0064, 0xFF9C and ch1 = 0x0010 x4, last on the final byte -> words 0x0000_0003, 0x0100_0000; last on the second word; size 8.
REQ-037 SHALL cover last on the first byte -> single word 0xFFFF_0000 with last; size 4.
REQ-038 SHALL cover 6 samples with the REQ-036 pattern, then last -> with PARTIAL_FLUSH_EN, 4 words ending 0x0001_0001, 0x0101_0000; without it, 2 words.
REQ-039 SHALL cover i_tmanager_ready held low for 20 cycles over 3 windows with OUT_DEPTH=4 -> o_tready low while free slots < 2, no word lost or duplicated.
REQ-040 SHALL cover i_rst asserted mid-window, then a fresh packet -> output identical to a run from power-up.
REQ-041 SHALL cover last on a byte that leaves half a sample -> the partial sample ignored, counts unchanged.
